// File: rtl/mul_sequencer.sv
// mul_sequencer: EX-stage controller for the iterative M-extension multiplier.
// It accepts a multiply from EX and stalls EX while the op runs. It issues a
// one-cycle start to the multiplier, waits for done (bounded by a timeout), and
// returns the result with its rd to writeback. A one-entry value-tagged result
// cache lets a repeated identical multiply complete without re-running the
// multiplier. After a flush it drains a multiply that is still in flight.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   ex_valid, ex_mul_op,     op request from EX (fields stable while stall_ex)
//   ex_rs1, ex_rs2, ex_rd
//   flush                    kill the current op
//   stall_ex                 hold EX (combinational)
//   wb_valid, wb_rd, wb_data one-cycle writeback strobe with rd and result
//   mul_err                  one-cycle pulse when an op times out (with RESP)
//   mul_start                start pulse to the multiplier
//   mul_opcode, mul_op1,     registered op/operands to the multiplier
//   mul_op2
//   mul_done, mul_result     completion and result from the multiplier
//
// state | meaning
// IDLE  | waiting for an op from EX; cache lookup happens here
// ISSUE | start pulse to the multiplier, timeout counter cleared
// WAIT  | waiting for mul_done or timeout
// RESP  | writeback strobe (suppressed by flush)
// DRAIN | flushed op still in the multiplier; wait for done/timeout, discard

module mul_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter bit CACHE_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  ex_mul_op,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        stall_ex,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mul_err,
    output logic        mul_start,
    output logic [1:0]  mul_opcode,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic        mul_done,
    input  logic [31:0] mul_result
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic          cache_valid;
    logic [1:0]    cache_op;
    logic [31:0]   cache_rs1;
    logic [31:0]   cache_rs2;
    logic [31:0]   cache_data;

    logic accept;
    logic hit;
    logic timeout;

    assign accept  = (state == IDLE) && ex_valid && !flush;
    assign hit     = CACHE_EN && cache_valid && (cache_op == ex_mul_op) &&
                     (cache_rs1 == ex_rs1) && (cache_rs2 == ex_rs2);
    assign timeout = (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush outranks mul_done, and mul_done outranks timeout in the same cycle.
    always_comb begin
        state_next = state;
        stall_ex   = ex_valid;
        mul_start  = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = hit ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (mul_done || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                stall_ex   = 1'b0;
                wb_valid   = !flush;
                state_next = IDLE;
            end
            DRAIN: begin
                if (mul_done || timeout) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            cache_valid <= 1'b0;
            cache_op    <= '0;
            cache_rs1   <= '0;
            cache_rs2   <= '0;
            cache_data  <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            mul_err     <= 1'b0;
            mul_opcode  <= '0;
            mul_op1     <= '0;
            mul_op2     <= '0;
        end else begin
            mul_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_rd <= ex_rd;
                        if (hit) begin
                            wb_data <= cache_data;
                        end else begin
                            mul_opcode <= ex_mul_op;
                            mul_op1    <= ex_rs1;
                            mul_op2    <= ex_rs2;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (!timeout) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (!flush) begin
                        if (mul_done) begin
                            wb_data     <= mul_result;
                            cache_valid <= 1'b1;
                            cache_op    <= mul_opcode;
                            cache_rs1   <= mul_op1;
                            cache_rs2   <= mul_op2;
                            cache_data  <= mul_result;
                        end else if (timeout) begin
                            wb_data <= '0;
                            mul_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Keeps counting from WAIT so the bound is measured from issue.
                    if (!timeout) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: a behavioural 32-cycle multiplier answers
// mul_start, expected writebacks are queued as ops are driven and popped
// when wb_valid appears.

module tb_mul_sequencer;

    localparam int MLAT = 32;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_mul_op;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall_ex;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mul_err;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic        mul_done;
    logic [31:0] mul_result;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int n_start = 0;
    int n_wb = 0;
    int n_errp = 0;
    int last_start = -1;
    logic [36:0] sb_q[$];

    bit          auto_done = 1'b1;
    bit          mdl_busy = 1'b0;
    int          mdl_cnt = 0;
    logic [31:0] mdl_res = '0;

    mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_mul_op  (ex_mul_op),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .stall_ex   (stall_ex),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mul_err    (mul_err),
        .mul_start  (mul_start),
        .mul_opcode (mul_opcode),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [65:0] xa, xb, p;
        xa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
        xb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model: done MLAT+1 cycles after the start pulse.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mdl_busy   = 1'b0;
            mdl_cnt    = 0;
            mul_done   = 1'b0;
            mul_result = '0;
        end else begin
            mul_done = 1'b0;
            if (mul_start) begin
                mdl_busy = auto_done;
                mdl_cnt  = MLAT;
                mdl_res  = ref_mul(mul_opcode, mul_op1, mul_op2);
            end else if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    mul_done   = 1'b1;
                    mul_result = mdl_res;
                    mdl_busy   = 1'b0;
                end else begin
                    mdl_cnt--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start) begin
            n_start++;
            last_start = cyc;
        end
        if (wb_valid) n_wb++;
        if (mul_err) n_errp++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                          input bit exp_err, input int exp_starts);
        logic [36:0] exp_e;
        int s0, w0, e0;
        bit stall_bad;
        sb_q.push_back({rd, exp_err ? 32'h0 : ref_mul(op, a, b)});
        step();
        cyc = 0;
        s0 = n_start;
        w0 = n_wb;
        e0 = n_errp;
        stall_bad = 1'b0;
        ex_valid = 1'b1;
        ex_mul_op = op;
        ex_rs1 = a;
        ex_rs2 = b;
        ex_rd = rd;
        flush = 1'b0;
        #1;
        while (!wb_valid && cyc < 200) begin
            if (!stall_ex) stall_bad = 1'b1;
            step();
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_stall_held"}, 64'(stall_bad), 64'd0);
        chk({tag, "_stall_drop"}, 64'(stall_ex), 64'd0);
        exp_e = sb_q.pop_front();
        chk({tag, "_rd_data"}, 64'({wb_rd, wb_data}), 64'(exp_e));
        chk({tag, "_err"}, 64'(mul_err), 64'(exp_err));
        if (exp_starts == 1) chk({tag, "_start_cyc"}, 64'(last_start), 64'd1);
        ex_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_wb_count"}, 64'(n_wb - w0), 64'd1);
        chk({tag, "_starts"}, 64'(n_start - s0), 64'(exp_starts));
        chk({tag, "_err_count"}, 64'(n_errp - e0), 64'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0;
        rst = 1'b1;
        ex_valid = 1'b0;
        flush = 1'b0;
        ex_mul_op = '0;
        ex_rs1 = '0;
        ex_rs2 = '0;
        ex_rd = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst_ctrl", 64'({wb_valid, mul_err, mul_start, stall_ex}), 64'd0);
        chk("rst_wb", 64'({wb_rd, wb_data, mul_opcode}), 64'd0);
        chk("rst_ops", 64'({mul_op1, mul_op2}), 64'd0);
        ex_valid = 1'b1;
        #1;
        chk("rst_stall_follow", 64'(stall_ex), 64'd1);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Misses, a hit, and all four opcodes.
        run_op("miss_mul",   2'b00, 32'd7, 32'd6, 5'd5, 3 + MLAT, 1'b0, 1);
        run_op("hit_mul",    2'b00, 32'd7, 32'd6, 5'd9, 1, 1'b0, 0);
        run_op("miss_mulhu", 2'b11, 32'd7, 32'd6, 5'd10, 3 + MLAT, 1'b0, 1);
        run_op("mulh",       2'b01, 32'hFFFF_FFFD, 32'd5, 5'd11, 3 + MLAT, 1'b0, 1);
        run_op("mulhsu",     2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 3 + MLAT, 1'b0, 1);
        run_op("mulhu",      2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 3 + MLAT, 1'b0, 1);

        // Timeout: the result is zero, the err pulse is single, no cache write.
        auto_done = 1'b0;
        run_op("timeout", 2'b00, 32'd9, 32'd9, 5'd3, 43, 1'b1, 1);
        auto_done = 1'b1;
        run_op("after_timeout", 2'b00, 32'd9, 32'd9, 5'd3, 3 + MLAT, 1'b0, 1);

        // Flush in WAIT with a new op arriving; drain, then issue the new op.
        w0 = n_wb;
        s0 = n_start;
        step();
        cyc = 0;
        ex_valid = 1'b1;
        ex_mul_op = 2'b00;
        ex_rs1 = 32'd11;
        ex_rs2 = 32'd13;
        ex_rd = 5'd4;
        repeat (10) step();
        flush = 1'b1;
        ex_rs1 = 32'd3;
        ex_rs2 = 32'd4;
        ex_rd = 5'd6;
        sb_q.push_back({5'd6, 32'd12});
        step();
        flush = 1'b0;
        #1;
        chk("fw_drain_stall", 64'(stall_ex), 64'd1);
        while (!wb_valid && cyc < 200) step();
        chk("fw_lat", 64'(cyc), 64'd70);
        chk("fw_issue_cyc", 64'(last_start), 64'd36);
        chk("fw_rd_data", 64'({wb_rd, wb_data}), 64'(sb_q.pop_front()));
        ex_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("fw_wb_count", 64'(n_wb - w0), 64'd1);
        chk("fw_starts", 64'(n_start - s0), 64'd2);

        // Flush in RESP: strobe suppressed, cache still written.
        w0 = n_wb;
        step();
        cyc = 0;
        ex_valid = 1'b1;
        ex_mul_op = 2'b00;
        ex_rs1 = 32'd5;
        ex_rs2 = 32'd5;
        ex_rd = 5'd2;
        #1;
        while (!wb_valid && cyc < 200) step();
        chk("fr_resp_cyc", 64'(cyc), 64'(3 + MLAT));
        flush = 1'b1;
        #1;
        chk("fr_suppress", 64'(wb_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("fr_wb_count", 64'(n_wb - w0), 64'd0);
        run_op("fr_replay_hit", 2'b00, 32'd5, 32'd5, 5'd2, 1, 1'b0, 0);

        // Async reset while in WAIT.
        step();
        cyc = 0;
        ex_valid = 1'b1;
        ex_mul_op = 2'b00;
        ex_rs1 = 32'd6;
        ex_rs2 = 32'd7;
        ex_rd = 5'd8;
        repeat (10) step();
        chk("ar_pre_op1", 64'(mul_op1), 64'd6);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_ctrl", 64'({wb_valid, mul_err, mul_start}), 64'd0);
        chk("ar_wb", 64'({wb_rd, wb_data, mul_opcode}), 64'd0);
        chk("ar_ops", 64'({mul_op1, mul_op2}), 64'd0);
        chk("ar_stall_follow", 64'(stall_ex), 64'd1);
        ex_valid = 1'b0;
        step();
        rst = 1'b1;
        run_op("ar_post_miss", 2'b00, 32'd5, 32'd5, 5'd2, 3 + MLAT, 1'b0, 1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Pipeline-side controller for the iterative multiplier in the M-extension execute stage. Accepts a multiply from the EX stage and stalls EX while it runs. Issues a one-cycle start to the multiplier, waits for `done` with a timeout, then returns the result with its destination register to writeback. It also holds a one-entry result cache, so a repeated identical multiply (same opcode and operand values) completes without re-running the 32-iteration loop, and it drains the multiplier safely after a pipeline flush.

## Interface
- `TIMEOUT_CYCLES`, default 40: WAIT/DRAIN cycles before the op is declared failed.
- `CACHE_EN`, default 1: 0 disables the result cache (every op misses).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (resets while 0).
- `ex_valid` in 1: EX holds a multiply. Fields are stable while `stall_ex`=1.
- `ex_mul_op` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `ex_rs1`, `ex_rs2` in 32 each: operand values.
- `ex_rd` in 5: destination register.
- `flush` in 1: kill the current op.
- `stall_ex` out 1: hold EX (combinational).
- `wb_valid` out 1: one-cycle result strobe.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.
- `mul_err` out 1: one-cycle timeout pulse.
- `mul_start` out 1: start pulse to the multiplier.
- `mul_opcode` out 2, `mul_op1` out 32, `mul_op2` out 32: registered, stable from ISSUE until the next ISSUE.
- `mul_done` in 1, `mul_result` in 32: from the multiplier.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN. Reset state is IDLE.
- IDLE with `ex_valid`=1 and `flush`=0:
  - Cache hit (`CACHE_EN`, cache valid, and op, rs1, rs2 all equal the cached values): load `wb_data` from the cache, go to RESP.
  - Miss: latch op, operands and rd into `mul_*`/rd registers, go to ISSUE.
- ISSUE: `mul_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On `mul_done`=1: capture `mul_result` into `wb_data`, write the cache (op, rs1, rs2, result, valid=1), go to RESP.
  - When the counter reaches `TIMEOUT_CYCLES`: `wb_data`=0, pulse `mul_err`, do not update the cache, go to RESP.
- RESP: `wb_valid`=1 with `wb_rd`/`wb_data`. Go to IDLE.
- `stall_ex` = `ex_valid` & (state != RESP). It drops during the RESP cycle so EX advances exactly once per op.
- Flush:
  - In ISSUE or WAIT: go to DRAIN. The ISSUE start pulse is still emitted. No `wb_valid`, no cache write.
  - In RESP: suppress `wb_valid`, go to IDLE.
  - In IDLE: the op is not accepted.
- DRAIN: wait for `mul_done` or timeout, then go to IDLE. The result is discarded, `mul_err` is not pulsed, and `stall_ex` follows `ex_valid`.
- `mul_done` is ignored in every state except WAIT and DRAIN.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Increments each WAIT/DRAIN cycle and saturates at the limit.
- The cache is invalidated only by reset. Entries are value-tagged, so no other invalidation is needed.

## Timing
- Reset values:
  - State IDLE, cache valid 0.
  - `wb_valid`, `wb_rd`, `wb_data`, `mul_err`, `mul_start`, `mul_opcode`, `mul_op1`, `mul_op2` all 0.
  - `stall_ex` equals `ex_valid`.
- Miss latency:
  - Cycle 0: op seen in IDLE.
  - Cycle 1: ISSUE (`mul_start`).
  - WAIT from cycle 2.
  - `mul_done` seen at cycle d puts `wb_valid` at d+1. With the 32-iteration multiplier, `wb_valid` lands about 35 cycles after cycle 0.
- Hit latency: IDLE at cycle 0, `wb_valid` at cycle 1. EX is stalled exactly 1 cycle.
- Back-to-back: a new op in IDLE the cycle after RESP is accepted with no bubble beyond the latencies above.
- `flush` takes priority over `mul_done` in the same cycle: the result is dropped.
- Reset (`rst`=0) mid-operation returns to IDLE immediately. The multiplier shares the reset.

## Test plan
- Miss: MUL, rs1=7, rs2=6, rd=5 → one `mul_start` at cycle 1. `stall_ex` stays high until RESP. `wb_valid` with rd=5, data=42, exactly once.
- Hit: repeat MUL 7×6 right after the first → no `mul_start`. `wb_valid` at cycle 1 with data 42. MULHU 7×6 afterwards misses and issues.
- Timeout: hold `mul_done`=0 → `mul_err` pulses once at counter=40, `wb_data`=0, cache not updated (same op re-issues next time).
- Flush in WAIT at cycle 10, with a new MUL 3×4 arriving → state goes to DRAIN, no `wb_valid` for the killed op. The new op is issued only after the old `mul_done`, then writes back 12.
- Flush in RESP → `wb_valid` stays 0. Cache holds the result, so the same op replayed hits.
- Async reset asserted in WAIT → all outputs go to their reset values without waiting for a clock edge. The next op misses (cache invalid).
